vdp_vram_arbiter: RTL and testbench
===================================

VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

Interface
REQ-001 CLK21M  in  1  system clock, 21.48 MHz.
REQ-002 RESET  in  1  asynchronous, active-high reset.
REQ-003 DOTSTATE  in  2  dot phase; sequence 00->01->11->10->00.
REQ-004 SPVRAMACCESSING  in  1  sprite engine owns VRAM while high.
REQ-005 SPRAMADR  in  17  sprite engine VRAM address.
REQ-006 CPU_REQ / CPU_WE  in  1 / 1  CPU access request, held until CPU_ACK; write when CPU_WE=1.
REQ-007 CPU_ADR / CPU_DBO  in  17 / 8  CPU address and write data.
REQ-008 CPU_ACK  out  1  one-clock completion pulse.
REQ-009 CPU_DBI  out  8  CPU read data, valid from the CPU_ACK clock until the next CPU read completes.
REQ-010 CMD_REQ, CMD_WE, CMD_ADR, CMD_DBO, CMD_ACK, CMD_DBI  same widths and rules as the CPU ports, for the command engine.
REQ-011 PRAMADR  out  17  VRAM address.
REQ-012 PRAMDBO  out  8  VRAM write data.
REQ-013 PRAMWE_N  out  1  VRAM write strobe, active low.
REQ-014 PRAMDAT  in  8  VRAM read data; the VRAM has two-clock read latency.

Function
REQ-015 One access slot per dot (4 clocks); the arbitration decision is registered on the clock where DOTSTATE=10.
REQ-016 Slot states: IDLE, SPR, CPU, CMD; the next state is chosen only at a DOTSTATE=10 clock and held for the whole slot.
REQ-017 Priority at each decision:
  - SPVRAMACCESSING=1 -> SPR;
  - else pending CPU_REQ -> CPU;
  - else pending CMD_REQ -> CMD;
  - else IDLE.
REQ-018 SPR slot: PRAMADR=SPRAMADR registered every clock of the slot; PRAMWE_N=1; no ACK is issued.
REQ-019 CPU/CMD slot: address, write data and WE are latched at the decision clock and held steady for the whole slot.
REQ-020 Write slots: PRAMWE_N=0 during DOTSTATE 00 and 01 of the slot, 1 otherwise.
REQ-021 Read slots: PRAMDAT is sampled into CPU_DBI/CMD_DBI at the DOTSTATE=11 clock of the slot.
REQ-022 The ACK pulses on the DOTSTATE=11 clock of the slot, for both reads and writes.
REQ-023 Request latency: a request asserted before a decision clock is acknowledged 4 clocks later, provided it wins that decision.
REQ-024 A request deasserted before it is granted is dropped; a request deasserted after grant still completes but the ACK is ignored.
REQ-025 A requester SHALL NOT be granted again within the same slot in which it was acknowledged; a REQ still high at the next decision is treated as a new access.
REQ-026 SPVRAMACCESSING rising mid-slot does not abort the current CPU/CMD slot; the sprite engine gets the next slot.
REQ-027 IDLE slots: PRAMADR holds its last value; PRAMWE_N=1.
REQ-028 CPU and CMD requests pending while the sprite engine owns VRAM wait with no timeout.

Reset
REQ-029 RESET forces:
  - state IDLE;
  - PRAMADR=0, PRAMDBO=0, PRAMWE_N=1;
  - CPU_ACK=0, CMD_ACK=0, CPU_DBI=0, CMD_DBI=0;
  - round-robin pointer = CPU.
REQ-030 RESET asserted mid-slot aborts the access immediately: no ACK, no further write strobe. After release, the first decision is made at the next DOTSTATE=10 clock.

Configuration
REQ-031 Macro VDP_VRAM_ARB_FAIR_EN.
  - Defined: when CPU and CMD are both pending and the sprite engine is not active, grant alternates using a 1-bit pointer that toggles after each CPU or CMD grant.
  - Undefined: fixed CPU-over-CMD priority per REQ-017; no pointer exists.

Verification
REQ-032 CPU write, CPU_ADR=0x03800, CPU_DBO=0xFF, idle bus -> PRAMWE_N low for 2 clocks with PRAMADR=0x03800, PRAMDBO=0xFF; CPU_ACK 4 clocks after the decision.
REQ-033 CMD read of 0x01B03 with VRAM content 12 -> CMD_DBI=0x0C on the CMD_ACK clock; PRAMWE_N stays 1.
REQ-034 SPVRAMACCESSING=1 with CPU_REQ pending -> no CPU_ACK while sprite slots run; CPU_ACK arrives in the first slot after SPVRAMACCESSING falls.
REQ-035 CPU_REQ and CMD_REQ held continuously:
  - without the macro, CMD is never granted;
  - with VDP_VRAM_ARB_FAIR_EN, grants alternate CPU, CMD, CPU, CMD.
REQ-036 RESET pulsed during the DOTSTATE=00 clock of a CPU write slot -> PRAMWE_N=1 immediately; no CPU_ACK; all outputs hold reset values.
REQ-037 CPU_REQ raised and dropped before the decision clock -> no grant, no ACK, and the slot is IDLE.

Source files
------------

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - VDP VRAM slot arbiter for sprite engine, CPU and command engine
//
// One VRAM access slot per dot (four clocks). The owner of the next slot is
// registered on the clock where dotstate_i = 2'b10 and held for the whole slot.
// Priority: sprite engine, then CPU, then command engine. Build option
// VDP_VRAM_ARB_FAIR_EN makes contended CPU/CMD grants alternate through a 1-bit
// pointer that toggles on every CPU or CMD grant.
//
// Ports
//   clk21m_i           system clock (21.48 MHz)
//   reset_i            asynchronous active-high reset
//   dotstate_i         dot phase, 00 -> 01 -> 11 -> 10 -> 00
//   spvramaccessing_i  sprite engine owns VRAM while high
//   spramadr_i         sprite engine VRAM address
//   cpu_req_i/we_i     CPU request (held until ack) and write enable
//   cpu_adr_i/dbo_i    CPU address and write data
//   cpu_ack_o          one-clock completion pulse
//   cpu_dbi_o          CPU read data, held until the next CPU read completes
//   cmd_*              same set of ports for the command engine
//   pramadr_o          VRAM address
//   pramdbo_o          VRAM write data
//   pramwe_n_o         VRAM write strobe, active low
//   pramdat_i          VRAM read data, two-clock read latency
module vdp_vram_arbiter (
  input  logic        clk21m_i,
  input  logic        reset_i,
  input  logic [1:0]  dotstate_i,
  input  logic        spvramaccessing_i,
  input  logic [16:0] spramadr_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [16:0] cpu_adr_i,
  input  logic [7:0]  cpu_dbo_i,
  output logic        cpu_ack_o,
  output logic [7:0]  cpu_dbi_o,
  input  logic        cmd_req_i,
  input  logic        cmd_we_i,
  input  logic [16:0] cmd_adr_i,
  input  logic [7:0]  cmd_dbo_i,
  output logic        cmd_ack_o,
  output logic [7:0]  cmd_dbi_o,
  output logic [16:0] pramadr_o,
  output logic [7:0]  pramdbo_o,
  output logic        pramwe_n_o,
  input  logic [7:0]  pramdat_i
);

  localparam logic [1:0] DS_00 = 2'b00;
  localparam logic [1:0] DS_01 = 2'b01;
  localparam logic [1:0] DS_11 = 2'b11;
  localparam logic [1:0] DS_10 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPR  = 2'd1,
    ST_CPU  = 2'd2,
    ST_CMD  = 2'd3
  } slot_e;

  slot_e       state_q, state_d;

  logic [16:0] pramadr_q, pramadr_d;
  logic [7:0]  pramdbo_q, pramdbo_d;
  logic        pramwe_n_q, pramwe_n_d;
  logic        slot_we_q, slot_we_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        cmd_ack_q, cmd_ack_d;
  logic [7:0]  cpu_dbi_q, cpu_dbi_d;
  logic [7:0]  cmd_dbi_q, cmd_dbi_d;

  logic        decide;
  logic        pick_cpu;
  logic        unused_ds;

  // The last clock of every slot doubles as the decision clock for the next one.
  assign decide    = (dotstate_i == DS_10);
  assign unused_ds = (dotstate_i == DS_00);

`ifdef VDP_VRAM_ARB_FAIR_EN
  // ptr_q = 0 favours the CPU on a tie, 1 favours the command engine.
  logic ptr_q, ptr_d;

  assign pick_cpu = cpu_req_i & (~cmd_req_i | ~ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (decide && ((state_d == ST_CPU) || (state_d == ST_CMD))) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk21m_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_cpu = cpu_req_i;
`endif

  // Slot owner: only ever changes on the decision clock.
  always_ff @(posedge clk21m_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (decide) begin
      if (spvramaccessing_i) begin
        state_d = ST_SPR;
      end else if (pick_cpu) begin
        state_d = ST_CPU;
      end else if (cmd_req_i) begin
        state_d = ST_CMD;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // VRAM-side datapath and requester responses.
  always_comb begin
    pramadr_d  = pramadr_q;
    pramdbo_d  = pramdbo_q;
    pramwe_n_d = pramwe_n_q;
    slot_we_d  = slot_we_q;
    cpu_ack_d  = 1'b0;
    cmd_ack_d  = 1'b0;
    cpu_dbi_d  = cpu_dbi_q;
    cmd_dbi_d  = cmd_dbi_q;

    if (decide) begin
      // Latch the winner's access so a requester dropping its request
      // mid-slot cannot disturb the VRAM cycle already under way.
      pramwe_n_d = 1'b1;
      slot_we_d  = 1'b0;
      case (state_d)
        ST_SPR: begin
          pramadr_d = spramadr_i;
        end
        ST_CPU: begin
          pramadr_d  = cpu_adr_i;
          pramdbo_d  = cpu_dbo_i;
          slot_we_d  = cpu_we_i;
          pramwe_n_d = ~cpu_we_i;
        end
        ST_CMD: begin
          pramadr_d  = cmd_adr_i;
          pramdbo_d  = cmd_dbo_i;
          slot_we_d  = cmd_we_i;
          pramwe_n_d = ~cmd_we_i;
        end
        default: begin
        end
      endcase
    end else begin
      // The sprite engine steers the address live for its whole slot.
      if (state_q == ST_SPR) begin
        pramadr_d = spramadr_i;
      end

      // Strobe was opened at the decision clock; closing it here leaves it
      // low for exactly the 00 and 01 phases of the slot.
      if (dotstate_i == DS_01) begin
        pramwe_n_d = 1'b1;
      end

      // By the 11 clock the two-clock read latency has elapsed.
      if (dotstate_i == DS_11) begin
        if (state_q == ST_CPU) begin
          cpu_ack_d = 1'b1;
          if (!slot_we_q) begin
            cpu_dbi_d = pramdat_i;
          end
        end
        if (state_q == ST_CMD) begin
          cmd_ack_d = 1'b1;
          if (!slot_we_q) begin
            cmd_dbi_d = pramdat_i;
          end
        end
      end
    end

    // Keeps the full phase decode visible without adding behaviour.
    if (unused_ds && decide) begin
      pramwe_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk21m_i or posedge reset_i) begin
    if (reset_i) begin
      pramadr_q  <= 17'd0;
      pramdbo_q  <= 8'd0;
      pramwe_n_q <= 1'b1;
      slot_we_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cmd_ack_q  <= 1'b0;
      cpu_dbi_q  <= 8'd0;
      cmd_dbi_q  <= 8'd0;
    end else begin
      pramadr_q  <= pramadr_d;
      pramdbo_q  <= pramdbo_d;
      pramwe_n_q <= pramwe_n_d;
      slot_we_q  <= slot_we_d;
      cpu_ack_q  <= cpu_ack_d;
      cmd_ack_q  <= cmd_ack_d;
      cpu_dbi_q  <= cpu_dbi_d;
      cmd_dbi_q  <= cmd_dbi_d;
    end
  end

  assign pramadr_o  = pramadr_q;
  assign pramdbo_o  = pramdbo_q;
  assign pramwe_n_o = pramwe_n_q;
  assign cpu_ack_o  = cpu_ack_q;
  assign cmd_ack_o  = cmd_ack_q;
  assign cpu_dbi_o  = cpu_dbi_q;
  assign cmd_dbi_o  = cmd_dbi_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// tb/tb_vdp_vram_arbiter.sv - randomized self-checking bench for vdp_vram_arbiter
module tb_vdp_vram_arbiter;

  localparam int NCYC  = 2400;
  localparam int K_IDLE = 0;
  localparam int K_SPR  = 1;
  localparam int K_CPU  = 2;
  localparam int K_CMD  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dotstate;
  logic        spv;
  logic [16:0] spramadr;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [16:0] cpu_adr;
  logic [7:0]  cpu_dbo, cpu_dbi;
  logic        cmd_req, cmd_we, cmd_ack;
  logic [16:0] cmd_adr;
  logic [7:0]  cmd_dbo, cmd_dbi;
  logic [16:0] pramadr;
  logic [7:0]  pramdbo;
  logic        pramwe_n;
  logic [7:0]  pramdat;

  always #5 clk = ~clk;

  vdp_vram_arbiter dut (
    .clk21m_i          (clk),
    .reset_i           (rst),
    .dotstate_i        (dotstate),
    .spvramaccessing_i (spv),
    .spramadr_i        (spramadr),
    .cpu_req_i         (cpu_req),
    .cpu_we_i          (cpu_we),
    .cpu_adr_i         (cpu_adr),
    .cpu_dbo_i         (cpu_dbo),
    .cpu_ack_o         (cpu_ack),
    .cpu_dbi_o         (cpu_dbi),
    .cmd_req_i         (cmd_req),
    .cmd_we_i          (cmd_we),
    .cmd_adr_i         (cmd_adr),
    .cmd_dbo_i         (cmd_dbo),
    .cmd_ack_o         (cmd_ack),
    .cmd_dbi_o         (cmd_dbi),
    .pramadr_o         (pramadr),
    .pramdbo_o         (pramdbo),
    .pramwe_n_o        (pramwe_n),
    .pramdat_i         (pramdat)
  );

  function automatic logic [7:0] pat(input logic [16:0] a);
    if (a == 17'h01B03) return 8'h0C;
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
  endfunction

  // VRAM with two-clock read latency
  logic [7:0] vram [0:131071];
  logic [7:0] rd1;
  bit         vram_ready;

  always @(posedge clk) begin
    if (!vram_ready) begin
      for (int i = 0; i < 131072; i++) vram[i] <= pat(17'(i));
      vram_ready <= 1'b1;
    end else if (!pramwe_n) begin
      vram[pramadr] <= pramdbo;
    end
    rd1     <= vram[pramadr];
    pramdat <= rd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: slot-level view of the arbiter
  logic [7:0]  ref_mem [0:131071];
  int          kind, off;
  logic [16:0] s_adr, e_adr;
  logic        s_we;
  logic [7:0]  s_dbo;
  logic        e_wen, e_cpu_ack, e_cmd_ack;
  logic [7:0]  e_cpu_dbi, e_cmd_dbi;
`ifdef VDP_VRAM_ARB_FAIR_EN
  bit          ptr;
`endif
  logic [1:0]  cur_ph;

  // Requester agents (index 0 = CPU, 1 = CMD); st 0 idle, 1 pending, 2 granted
  int          r_st  [2];
  bit          r_req [2];
  bit          r_we  [2];
  logic [16:0] r_adr [2];
  logic [7:0]  r_dbo [2];
  int          r_gap [2];
  bit          r_first [2];

  bit rst_hold, rst_done;
  int win_cpu_acks, win_cmd_acks, spr_cpu_acks;

  function automatic logic [1:0] nxt_ph(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    kind = K_IDLE; off = 4;
    e_adr = '0; e_wen = 1'b1; e_cpu_ack = 1'b0; e_cmd_ack = 1'b0;
    e_cpu_dbi = '0; e_cmd_dbi = '0;
`ifdef VDP_VRAM_ARB_FAIR_EN
    ptr = 1'b0;
`endif
  endtask

  task automatic model_edge();
    int r;
    e_cpu_ack = 1'b0;
    e_cmd_ack = 1'b0;
    if (cur_ph == 2'b10) begin
      kind = K_IDLE;
      if (spv) kind = K_SPR;
      else if (r_req[0] && r_req[1]) begin
`ifdef VDP_VRAM_ARB_FAIR_EN
        kind = ptr ? K_CMD : K_CPU;
`else
        kind = K_CPU;
`endif
      end
      else if (r_req[0]) kind = K_CPU;
      else if (r_req[1]) kind = K_CMD;
      off = 0;
      if (kind == K_SPR) e_adr = spramadr;
      else if (kind != K_IDLE) begin
        r = kind - K_CPU;
        s_adr = r_adr[r]; s_we = r_we[r]; s_dbo = r_dbo[r];
        e_adr = s_adr;
        r_st[r] = 2;
`ifdef VDP_VRAM_ARB_FAIR_EN
        ptr = ~ptr;
`endif
      end
    end else begin
      if (off < 4) off++;
      if (kind == K_SPR) e_adr = spramadr;
      if (off == 3 && (kind == K_CPU || kind == K_CMD)) begin
        r = kind - K_CPU;
        if (r == 0) e_cpu_ack = 1'b1; else e_cmd_ack = 1'b1;
        if (s_we) ref_mem[s_adr] = s_dbo;
        else if (r == 0) e_cpu_dbi = ref_mem[s_adr];
        else e_cmd_dbi = ref_mem[s_adr];
      end
    end
    e_wen = !((kind == K_CPU || kind == K_CMD) && s_we && off <= 1);
  endtask

  task automatic check_outputs();
    check_eq("pramadr", 32'(pramadr), 32'(e_adr));
    check_eq("pramwe_n", 32'(pramwe_n), 32'(e_wen));
    if (!e_wen) check_eq("pramdbo", 32'(pramdbo), 32'(s_dbo));
    check_eq("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
    check_eq("cmd_ack", 32'(cmd_ack), 32'(e_cmd_ack));
    check_eq("cpu_dbi", 32'(cpu_dbi), 32'(e_cpu_dbi));
    check_eq("cmd_dbi", 32'(cmd_dbi), 32'(e_cmd_dbi));
  endtask

  task automatic new_req(input int r);
    logic [16:0] base;
    r_st[r] = 1; r_req[r] = 1'b1;
    if (r_first[r]) begin
      r_first[r] = 1'b0;
      r_we[r]  = (r == 0);
      r_adr[r] = (r == 0) ? 17'h03800 : 17'h01B03;
      r_dbo[r] = 8'hFF;
    end else begin
      case ($urandom_range(0, 3))
        0:       base = 17'h03800;
        1:       base = 17'h01B00;
        2:       base = 17'h1FFF8;
        default: base = 17'h00000;
      endcase
      r_we[r]  = $urandom_range(0, 1) == 1;
      r_adr[r] = base + 17'($urandom_range(0, 7));
      r_dbo[r] = 8'($urandom);
    end
  endtask

  task automatic drive_next(input int cyc);
    int  mode;
    bit  acked;
    mode = (cyc >= 1200 && cyc < 1400) ? 1 : (cyc >= 1400 && cyc < 1480) ? 2 : 0;
    if (mode == 0) begin
      if ($urandom_range(0, 29) == 0) spv = ~spv;
    end else begin
      spv = (mode == 2);
    end
    spramadr = 17'($urandom);
    for (int r = 0; r < 2; r++) begin
      acked = (r == 0) ? e_cpu_ack : e_cmd_ack;
      if (acked) begin
        r_st[r] = 0;
        if (mode != 0 || $urandom_range(0, 1) == 1) new_req(r);
        else begin r_req[r] = 1'b0; r_gap[r] = $urandom_range(0, 6); end
      end else if (r_st[r] == 0) begin
        if (r_gap[r] > 0) r_gap[r]--;
        else if (mode != 0 || $urandom_range(0, 2) == 0) new_req(r);
      end else if (r_st[r] == 1) begin
        if (mode == 0 && $urandom_range(0, 19) == 0) begin r_st[r] = 0; r_req[r] = 1'b0; end
      end else begin
        if (mode == 0 && $urandom_range(0, 3) == 0) r_req[r] = 1'b0;
      end
    end
    cpu_req = r_req[0]; cpu_we = r_we[0]; cpu_adr = r_adr[0]; cpu_dbo = r_dbo[0];
    cmd_req = r_req[1]; cmd_we = r_we[1]; cmd_adr = r_adr[1]; cmd_dbo = r_dbo[1];
    cur_ph = nxt_ph(cur_ph);
    dotstate = cur_ph;
  endtask

  initial begin
    bit trig;
    for (int i = 0; i < 131072; i++) ref_mem[i] = pat(17'(i));
    for (int r = 0; r < 2; r++) begin
      r_st[r] = 0; r_req[r] = 1'b0; r_we[r] = 1'b0; r_adr[r] = '0; r_dbo[r] = '0;
      r_gap[r] = 2; r_first[r] = 1'b1;
    end
    s_adr = '0; s_we = 1'b0; s_dbo = '0;
    rst = 1'b1; cur_ph = 2'b00; dotstate = cur_ph; spv = 1'b0; spramadr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_dbo = '0;
    cmd_req = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dbo = '0;
    rst_hold = 1'b0; rst_done = 1'b0;
    win_cpu_acks = 0; win_cmd_acks = 0; spr_cpu_acks = 0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      cur_ph = nxt_ph(cur_ph);
      dotstate = cur_ph;
    end
    check_eq("rst_pramadr", 32'(pramadr), 32'd0);
    check_eq("rst_pramdbo", 32'(pramdbo), 32'd0);
    check_eq("rst_pramwe_n", 32'(pramwe_n), 32'd1);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    check_eq("rst_cpu_dbi", 32'(cpu_dbi), 32'd0);
    check_eq("rst_cmd_dbi", 32'(cmd_dbi), 32'd0);
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (rst_hold) begin
        rst = 1'b0;
        rst_hold = 1'b0;
      end else begin
        model_edge();
      end
      check_outputs();
      if (cyc >= 1210 && cyc < 1400) begin
        if (cpu_ack) win_cpu_acks++;
        if (cmd_ack) win_cmd_acks++;
      end
      if (cyc >= 1408 && cyc <= 1480 && cpu_ack) spr_cpu_acks++;

      trig = !rst_done && cyc > 300 && kind == K_CPU && s_we && off == 0;
      drive_next(cyc);

      // Abort a CPU write slot across its 00 clock.
      if (trig) begin
        rst = 1'b1;
        #1;
        check_eq("abort_pramwe_n", 32'(pramwe_n), 32'd1);
        check_eq("abort_pramadr", 32'(pramadr), 32'd0);
        check_eq("abort_pramdbo", 32'(pramdbo), 32'd0);
        check_eq("abort_cpu_ack", 32'(cpu_ack), 32'd0);
        check_eq("abort_cpu_dbi", 32'(cpu_dbi), 32'd0);
        model_reset();
        for (int r = 0; r < 2; r++) if (r_st[r] == 2) r_st[r] = r_req[r] ? 1 : 0;
        rst_hold = 1'b1;
        rst_done = 1'b1;
      end
    end

    check_eq("abort_exercised", 32'(rst_done), 32'd1);
    check_eq("spr_hold_cpu_acks", 32'(spr_cpu_acks), 32'd0);
`ifdef VDP_VRAM_ARB_FAIR_EN
    check_eq("fair_alternation", 32'((win_cpu_acks - win_cmd_acks <= 1) && (win_cmd_acks - win_cpu_acks <= 1) && win_cmd_acks > 0), 32'd1);
`else
    check_eq("fixed_prio_cmd_acks", 32'(win_cmd_acks), 32'd0);
    check_eq("fixed_prio_cpu_busy", 32'(win_cpu_acks > 20), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
